// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath width, NOP encoding, opcode field and fetch FSM encoding.
package mips_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    typedef logic [1:0] fetch_state_t;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with flush (to NOP), hold and load; also serves as the ID/EX register template.
module if_id_reg
    import mips_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         hold_i,
    input  logic         load_i,
    input  logic         valid_i,
    input  logic [W-1:0] instr_i,
    input  logic [W-1:0] pc4_i,
    output logic         valid_o,
    output logic [W-1:0] instr_o,
    output logic [W-1:0] pc4_o
);

    logic         valid_q;
    logic [W-1:0] instr_q;
    logic [W-1:0] pc4_q;

    // Flush wins over hold so a redirect can kill a stalled instruction.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_q <= 1'b0;
            instr_q <= W'(NOP_INSTR);
            pc4_q   <= '0;
        end else if (load_i && !hold_i) begin
            valid_q <= valid_i;
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC, single-outstanding imem request, skid buffer, IF/ID register.
// Optional performance counters are compiled in when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            id_stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic [5:0]      ifid_op_code
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_bubble_cnt
`endif
);
    import mips_pkg::NOP_INSTR;
    import mips_pkg::OPCODE_MSB;
    import mips_pkg::OPCODE_LSB;
    import mips_pkg::fetch_state_t;
    import mips_pkg::ST_FETCH;
    import mips_pkg::ST_WAIT;
    import mips_pkg::ST_HOLD;
    import mips_pkg::ST_DRAIN;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;

    logic            handshake;
    logic            can_load;
    logic [XLEN-1:0] rsp_pc4;
    logic            ld_valid;
    logic [XLEN-1:0] ld_instr;
    logic [XLEN-1:0] ld_pc4;

    assign imem_req_valid = (state_q == ST_FETCH) && !rst;
    assign imem_req_addr  = pc_q;
    assign handshake      = imem_req_valid && imem_req_ready;
    assign can_load       = !id_stall || !ifid_valid;
    assign rsp_pc4        = req_pc_q + XLEN'(4);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        ld_valid     = 1'b0;
        ld_instr     = XLEN'(NOP_INSTR);
        ld_pc4       = '0;

        if (branch_taken) begin
            pc_d         = {branch_target[XLEN-1:2], 2'b00};
            skid_instr_d = '0;
            skid_pc4_d   = '0;
            // An accepted-but-unanswered request is wrong-path: its response must be drained.
            case (state_q)
                ST_FETCH: state_d = handshake ? ST_DRAIN : ST_FETCH;
                ST_WAIT:  state_d = imem_rsp_valid ? ST_FETCH : ST_DRAIN;
                ST_HOLD:  state_d = ST_FETCH;
                default:  state_d = imem_rsp_valid ? ST_FETCH : ST_DRAIN;
            endcase
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (handshake) begin
                        req_pc_d = pc_q;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        pc_d = rsp_pc4;
                        if (can_load) begin
                            ld_valid = 1'b1;
                            ld_instr = imem_rsp_data;
                            ld_pc4   = rsp_pc4;
                            state_d  = ST_FETCH;
                        end else begin
                            skid_instr_d = imem_rsp_data;
                            skid_pc4_d   = rsp_pc4;
                            state_d      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (can_load) begin
                        ld_valid     = 1'b1;
                        ld_instr     = skid_instr_q;
                        ld_pc4       = skid_pc4_q;
                        skid_instr_d = '0;
                        skid_pc4_d   = '0;
                        state_d      = ST_FETCH;
                    end
                end
                default: begin
                    if (imem_rsp_valid) begin
                        state_d = ST_FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    // Every unstalled cycle loads something: a real instruction or a bubble.
    if_id_reg #(
        .W (XLEN)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .flush_i (branch_taken),
        .hold_i  (!can_load),
        .load_i  (1'b1),
        .valid_i (ld_valid),
        .instr_i (ld_instr),
        .pc4_i   (ld_pc4),
        .valid_o (ifid_valid),
        .instr_o (ifid_instr),
        .pc4_o   (ifid_pc_plus4)
    );

    assign ifid_op_code = ifid_instr[OPCODE_MSB:OPCODE_LSB];

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else if (!branch_taken && can_load) begin
            if (ld_valid && fetch_cnt_q != 32'hFFFF_FFFF) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (!ld_valid && bubble_cnt_q != 32'hFFFF_FFFF) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule
